// File: rtl/aes_round_ctrl.sv
`timescale 1ns/1ps
// Purpose: AES-128 round sequencer. It holds the state and round-key registers, walks the round counter and supplies rcon.
// Latency: NUM_ROUNDS+1 edges from the edge that accepts start to the edge that raises done. Back-to-back operation is supported.
// Backpressure: ready is low while rounds run and start is ignored then. Optional abort port under macro AES_ROUND_CTRL_ABORT_EN.
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] block_in,
    input  logic [127:0] key_in,
    input  logic [127:0] round_state_in,
    input  logic [127:0] round_key_in,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic         abort,
`endif
    output logic [127:0] state_out,
    output logic [127:0] key_out,
    output logic [3:0]   round_num,
    output logic         final_round,
    output logic [7:0]   rcon,
    output logic         ready,
    output logic         done,
    output logic [127:0] result
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    typedef enum logic {
        IDLE  = 1'b0,
        ROUND = 1'b1
    } fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   round_num_q, round_num_d;
    logic [127:0] state_out_q, state_out_d;
    logic [127:0] key_out_q, key_out_d;
    logic [127:0] result_q, result_d;
    logic         done_q, done_d;

    // Next-state logic. The initial AddRoundKey is folded into the load, so round 1 starts from block^key.
    always_comb begin
        fsm_d       = fsm_q;
        round_num_d = round_num_q;
        state_out_d = state_out_q;
        key_out_d   = key_out_q;
        result_d    = result_q;
        done_d      = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    state_out_d = block_in ^ key_in;
                    key_out_d   = key_in;
                    round_num_d = 4'd1;
                    fsm_d       = ROUND;
                end
            end
            ROUND: begin
`ifdef AES_ROUND_CTRL_ABORT_EN
                // Abort outranks the final-round edge: the operation is dropped with no done.
                if (abort) begin
                    round_num_d = 4'd0;
                    fsm_d       = IDLE;
                end else
`endif
                if (round_num_q == LAST_RND) begin
                    result_d    = round_state_in;
                    done_d      = 1'b1;
                    round_num_d = 4'd0;
                    fsm_d       = IDLE;
                end else begin
                    state_out_d = round_state_in;
                    key_out_d   = round_key_in;
                    round_num_d = round_num_q + 4'd1;
                end
            end
        endcase
    end

    // State registers; reset clears everything, including the held result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q       <= IDLE;
            round_num_q <= 4'd0;
            state_out_q <= '0;
            key_out_q   <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            round_num_q <= round_num_d;
            state_out_q <= state_out_d;
            key_out_q   <= key_out_d;
            result_q    <= result_d;
            done_q      <= done_d;
        end
    end

    // Round constant for the key expander, looked up from the current round index.
    always_comb begin
        rcon = 8'h00;
        case (round_num_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // The done cycle is already IDLE, so ready is high there and a new start is accepted.
    assign ready       = (fsm_q == IDLE);
    assign final_round = (fsm_q == ROUND) && (round_num_q == LAST_RND);
    assign round_num   = round_num_q;
    assign state_out   = state_out_q;
    assign key_out     = key_out_q;
    assign result      = result_q;
    assign done        = done_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
`timescale 1ns/1ps
// Bench for aes_round_ctrl. It supplies a behavioural AES-128 round datapath and key expander on the round_* ports.
// Every check samples on the falling clock edge. Inputs change right after that edge.
// The abort scenarios are compiled in only when AES_ROUND_CTRL_ABORT_EN is defined.
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam logic [7:0] RCON_TBL [0:15] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                                8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [127:0] block_in, key_in, rs_in, rk_in;
    logic [127:0] state_out, key_out, result;
    logic [3:0]   round_num;
    logic         final_round, ready, done;
    logic [7:0]   rcon;
`ifdef AES_ROUND_CTRL_ABORT_EN
    logic         abort;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    logic [127:0] prev_ct;

    aes_round_ctrl #(.NUM_ROUNDS(NR)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .block_in       (block_in),
        .key_in         (key_in),
        .round_state_in (rs_in),
        .round_key_in   (rk_in),
`ifdef AES_ROUND_CTRL_ABORT_EN
        .abort          (abort),
`endif
        .state_out      (state_out),
        .key_out        (key_out),
        .round_num      (round_num),
        .final_round    (final_round),
        .rcon           (rcon),
        .ready          (ready),
        .done           (done),
        .result         (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    // ---------------- AES-128 reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // S-box: multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq = x;
        logic [7:0] r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gm(sq, sq);
            r  = gm(r, sq);
        end
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk, input logic last);
        logic [7:0] a [16];
        logic [7:0] t [16];
        logic [7:0] m [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127 - 8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r + 4*c] = a[r + 4*((c + r) % 4)];
        for (int c = 0; c < 4; c++) begin
            m[4*c]   = gm(8'h02, t[4*c]) ^ gm(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
            m[4*c+1] = t[4*c] ^ gm(8'h02, t[4*c+1]) ^ gm(8'h03, t[4*c+2]) ^ t[4*c+3];
            m[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(8'h02, t[4*c+2]) ^ gm(8'h03, t[4*c+3]);
            m[4*c+3] = gm(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gm(8'h02, t[4*c+3]);
        end
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = last ? t[i] : m[i];
        return o ^ rk;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0 = k[127:96];
        logic [31:0] w1 = k[95:64];
        logic [31:0] w2 = k[63:32];
        logic [31:0] w3 = k[31:0];
        logic [31:0] t, n0, n1, n2, n3;
        t  = {w3[23:0], w3[31:24]};
        t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s = pt ^ key;
        logic [127:0] k = key;
        for (int r = 1; r <= NR; r++) begin
            k = next_key(k, RCON_TBL[r]);
            s = aes_round(s, k, r == NR);
        end
        return s;
    endfunction

    // External round datapath and key expander, driven by the controller's outputs.
    always_comb begin
        rk_in = next_key(key_out, rcon);
        rs_in = aes_round(state_out, rk_in, final_round);
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // One complete operation with per-round checks; optionally pulses start at rounds 3 and 7.
    task automatic run_op(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] ct, input bit inject);
        int e;
        start = 1'b1; block_in = pt; key_in = key;
        @(negedge clk);
        start = 1'b0;
        e = 1;
        chk("load state_out", state_out, pt ^ key);
        chk("load key_out", key_out, key);
        while (done !== 1'b1 && e <= NR + 4) begin
            chk("round_num", 128'(round_num), 128'(e));
            chk("rcon", 128'(rcon), 128'(RCON_TBL[e]));
            chk("final_round", 128'(final_round), 128'(e == NR));
            chk("ready in round", 128'(ready), 128'(0));
            if (inject && (e == 3 || e == 7)) begin
                start = 1'b1;
                block_in = {$urandom, $urandom, $urandom, $urandom};
                key_in   = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            e++;
        end
        start = 1'b0;
        chk("latency edges", 128'(e), 128'(NR + 1));
        chk("done pulse", 128'(done), 128'(1));
        chk("ready in done cycle", 128'(ready), 128'(1));
        chk("round_num after done", 128'(round_num), 128'(0));
        chk("final_round idle", 128'(final_round), 128'(0));
        chk("result", result, ct);
        prev_ct = ct;
        @(negedge clk);
        chk("done single cycle", 128'(done), 128'(0));
        chk("result held", result, ct);
        chk("ready idle", 128'(ready), 128'(1));
    endtask

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
        bit           inject;
    } vec_t;

    initial begin
        vec_t vecs [3];
        int cyc, ndone, last_done;
        int dcyc [3];
        int a, done_edge, next_free, exp_rn;
        bit in_rnd;
        logic [127:0] exp_ct;

        vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1};
        vecs[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32, 1'b0};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 1'b0};

        reset_n = 1'b0; start = 1'b0; block_in = '0; key_in = '0; prev_ct = '0;
`ifdef AES_ROUND_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset ready", 128'(ready), 128'(1));
        chk("reset done", 128'(done), 128'(0));
        chk("reset round_num", 128'(round_num), 128'(0));
        chk("reset rcon", 128'(rcon), 128'(0));
        chk("reset result", result, 128'(0));
        chk("reset final_round", 128'(final_round), 128'(0));

        // Known-answer vectors, one full operation each.
        for (int v = 0; v < 3; v++) run_op(vecs[v].pt, vecs[v].key, vecs[v].ct, vecs[v].inject);

        // start held high: each new operation is accepted in the done cycle.
        start = 1'b1; block_in = vecs[1].pt; key_in = vecs[1].key;
        cyc = 0; ndone = 0; last_done = -10;
        while (ndone < 3 && cyc < 45) begin
            @(negedge clk);
            cyc++;
            if (cyc == last_done + 1) chk("b2b new op round_num", 128'(round_num), 128'(1));
            if (done === 1'b1) begin
                dcyc[ndone] = cyc;
                ndone++;
                last_done = cyc;
                chk("b2b ready", 128'(ready), 128'(1));
                chk("b2b result", result, vecs[1].ct);
                if (ndone == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("b2b done count", 128'(ndone), 128'(3));
        if (ndone == 3) begin
            chk("b2b first done", 128'(dcyc[0]), 128'(NR + 1));
            chk("b2b period 1", 128'(dcyc[1] - dcyc[0]), 128'(NR + 1));
            chk("b2b period 2", 128'(dcyc[2] - dcyc[1]), 128'(NR + 1));
        end
        prev_ct = vecs[1].ct;
        @(negedge clk);
        chk("b2b stop ready", 128'(ready), 128'(1));
        chk("b2b stop round_num", 128'(round_num), 128'(0));

        // Reset in the middle of round 5: outputs clear without a clock edge and no done follows.
        start = 1'b1; block_in = vecs[0].pt; key_in = vecs[0].key;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre-reset round_num", 128'(round_num), 128'(5));
        #2 reset_n = 1'b0;
        #1;
        chk("async rst round_num", 128'(round_num), 128'(0));
        chk("async rst ready", 128'(ready), 128'(1));
        chk("async rst done", 128'(done), 128'(0));
        chk("async rst state_out", state_out, 128'(0));
        chk("async rst key_out", key_out, 128'(0));
        chk("async rst result", result, 128'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < NR + 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("no done after reset", 128'(ndone), 128'(0));
        chk("idle after reset", 128'(ready), 128'(1));
        run_op(vecs[1].pt, vecs[1].key, vecs[1].ct, 1'b0);

        // Random start traffic against a timing model: accept at edge a, rounds 1..NR after edges a..a+NR-1, done after edge a+NR.
        a = -100; done_edge = -100; next_free = 0; exp_ct = '0;
        for (int n = 0; n < 300; n++) begin
            start    = ($urandom_range(0, 3) == 0);
            block_in = {$urandom, $urandom, $urandom, $urandom};
            key_in   = {$urandom, $urandom, $urandom, $urandom};
            if (start && n >= next_free) begin
                a = n; done_edge = n + NR; next_free = n + NR + 1;
                exp_ct = aes_encrypt(block_in, key_in);
            end
            @(negedge clk);
            in_rnd = (n >= a) && (n < a + NR);
            exp_rn = in_rnd ? n - a + 1 : 0;
            if (n == done_edge) prev_ct = exp_ct;
            chk("rand done", 128'(done), 128'(n == done_edge));
            chk("rand ready", 128'(ready), 128'(!in_rnd));
            chk("rand round_num", 128'(round_num), 128'(exp_rn));
            chk("rand rcon", 128'(rcon), 128'(RCON_TBL[exp_rn]));
            chk("rand final_round", 128'(final_round), 128'(exp_rn == NR));
            chk("rand result", result, prev_ct);
        end
        start = 1'b0;
        repeat (NR + 2) @(negedge clk);
        if (a >= 0) prev_ct = exp_ct;
        chk("rand drain result", result, prev_ct);
        chk("rand drain ready", 128'(ready), 128'(1));

`ifdef AES_ROUND_CTRL_ABORT_EN
        // Abort at round 4: back to IDLE on the next edge, result untouched, no done.
        start = 1'b1; block_in = vecs[2].pt; key_in = vecs[2].key;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort4 round_num", 128'(round_num), 128'(4));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort4 ready", 128'(ready), 128'(1));
        chk("abort4 round_num", 128'(round_num), 128'(0));
        chk("abort4 done", 128'(done), 128'(0));
        chk("abort4 result", result, prev_ct);
        @(negedge clk);
        chk("abort4 no late done", 128'(done), 128'(0));
        // Abort on the final-round edge wins over completion.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (NR - 1) @(negedge clk);
        chk("abort10 round_num", 128'(round_num), 128'(NR));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort10 done", 128'(done), 128'(0));
        chk("abort10 ready", 128'(ready), 128'(1));
        chk("abort10 result", result, prev_ct);
        @(negedge clk);
        chk("abort10 no late done", 128'(done), 128'(0));
        run_op(vecs[0].pt, vecs[0].key, vecs[0].ct, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
